aurora_link_supervisor: RTL and testbench
=========================================

Name: aurora_link_supervisor

Overview:
Single-clock reset sequencer and health monitor for one Aurora channel, running on init_clk.
- Drives the core's gt_reset and reset inputs through a timed power-on sequence.
- Qualifies channel_up and raises link_ready to the TX/RX blocks only once the channel is stable.
- Runs soft recovery on link loss and full GT retries on bring-up timeout, latching a failure flag after too many retries.

Parameters:
GT_RST_CYCLES, 62, init_clk cycles gt_reset is held high in RST_GT
SYS_RST_CYCLES, 16, cycles reset_Aurora is held high with gt_reset low (RST_CORE, RECOVER)
STABLE_CYCLES, 8, consecutive synchronized-high channel_up samples required for link_ready
UP_TIMEOUT, 4096, cycles allowed in WAIT_UP before a retry
DOWN_FILTER, 4, consecutive synchronized-low samples in LINK_UP that count as a link drop
MAX_RETRIES, 7, full retries before FAILED (must be at most 15)
TMR_W, 16, shared timer width (must hold max(GT_RST_CYCLES, SYS_RST_CYCLES, UP_TIMEOUT))

Ports:
init_clk  in  1  sole clock
RST_N  in  1  asynchronous, active-low reset
channel_up  in  1  Aurora status, user_clk domain; asynchronous to init_clk
restart  in  1  single-cycle pulse; restarts the full sequence from any state
soft_reset_req  in  1  single-cycle pulse; core-only reset, honoured in LINK_UP only
gt_reset  out  1  to Aurora gt_reset
reset_Aurora  out  1  to Aurora reset
link_ready  out  1  active-high; TX/RX blocks are released when this is 1
link_failed  out  1  sticky failure flag
retry_cnt  out  4  full retries used in the current bring-up
link_drops  out  8  saturating count of filtered link drops
state_o  out  3  current state encoding

Behaviour:
- Reset (RST_N=0, asynchronous):
  - State RST_GT, gt_reset=1, reset_Aurora=1.
  - link_ready=0, link_failed=0, retry_cnt=0, link_drops=0.
  - Timer, stable/low counters and synchronizer flops cleared.
  - Sequence restarts on the first edge after RST_N rises.
- channel_up passes a 2-flop synchronizer to give cu_s; 2-cycle latency.
- All outputs are registered and decoded from next-state, so they change on the same edge as state_o.
- Timer: clears on every state change and increments each cycle otherwise.
- State encoding: RST_GT=0, RST_CORE=1, WAIT_UP=2, LINK_UP=3, RECOVER=4, FAILED=5; values 6 and 7 go to RST_GT.
- RST_GT: gt_reset=1, reset_Aurora=1. After exactly GT_RST_CYCLES cycles in the state, go to RST_CORE.
- RST_CORE: gt_reset=0, reset_Aurora=1. After exactly SYS_RST_CYCLES cycles, go to WAIT_UP.
- WAIT_UP: both resets 0, link_ready=0.
  - Stable counter increments while cu_s=1 and clears on cu_s=0.
  - When the stable counter reaches STABLE_CYCLES: go to LINK_UP and clear retry_cnt.
  - Otherwise, when the timer reaches UP_TIMEOUT:
    - if retry_cnt == MAX_RETRIES, go to FAILED;
    - else increment retry_cnt and go to RST_GT.
  - If both conditions hold on the same edge, LINK_UP wins.
- LINK_UP: link_ready=1.
  - Low counter increments while cu_s=0 and clears on cu_s=1.
  - Low counter reaching DOWN_FILTER: go to RECOVER and increment link_drops (saturates at 255).
  - soft_reset_req: go to RECOVER without incrementing link_drops.
- RECOVER: gt_reset=0, reset_Aurora=1, link_ready=0. After SYS_RST_CYCLES cycles, go to WAIT_UP. retry_cnt is unchanged.
- FAILED: gt_reset=1, reset_Aurora=1, link_failed=1. Holds until restart.
- Priority: restart > soft_reset_req > timer/channel events.
  - restart in any state: go to RST_GT, clear retry_cnt, clear link_failed; link_drops is kept.
  - soft_reset_req outside LINK_UP is ignored.
- link_ready is 1 in LINK_UP only and falls on the same edge the state leaves LINK_UP.

Test Plan:
1. Nominal bring-up (defaults), RST_N released, channel_up rises 5 cycles after entering WAIT_UP and stays high → gt_reset high for 62 cycles; reset_Aurora high for 78; link_ready rises on the 10th edge after channel_up rises; retry_cnt=0.
2. Glitch rejection: in WAIT_UP, channel_up high 5 cycles, low 3, then high → no link_ready until 8 consecutive cu_s-high samples after the second rise.
3. Drop filter: in LINK_UP, channel_up low 3 cycles → no state change. Then low for 6 cycles → RECOVER, reset_Aurora=1 for 16 cycles, gt_reset stays 0, link_drops=1. With channel_up high again, link_ready returns.
4. Timeout path (UP_TIMEOUT=64, MAX_RETRIES=2), channel_up stuck 0 → retry_cnt goes 1 then 2 with full GT sequences; third timeout → FAILED, link_failed=1, both resets 1. restart pulse → RST_GT, retry_cnt=0, link_failed=0.
5. RST_N asserted mid-RECOVER, with no clock edge → gt_reset=1, reset_Aurora=1, link_ready=0, link_drops=0, state_o=0 immediately.
6. restart and soft_reset_req on the same cycle in LINK_UP → state RST_GT, gt_reset=1, link_drops unchanged. Separately, soft_reset_req in WAIT_UP → ignored.

Source files
------------

// File: rtl/aurora_link_supervisor.sv
// Reset sequencer and health monitor for one Aurora channel on init_clk.
// Sequences gt_reset/reset, qualifies channel_up into link_ready, and handles recovery and retries.
module aurora_link_supervisor #(
    parameter int unsigned GT_RST_CYCLES  = 62,
    parameter int unsigned SYS_RST_CYCLES = 16,
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter int unsigned UP_TIMEOUT     = 4096,
    parameter int unsigned DOWN_FILTER    = 4,
    parameter int unsigned MAX_RETRIES    = 7,
    parameter int unsigned TMR_W          = 16
) (
    input  logic       init_clk,
    input  logic       RST_N,
    input  logic       channel_up,
    input  logic       restart,
    input  logic       soft_reset_req,
    output logic       gt_reset,
    output logic       reset_Aurora,
    output logic       link_ready,
    output logic       link_failed,
    output logic [3:0] retry_cnt,
    output logic [7:0] link_drops,
    output logic [2:0] state_o
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned LW = $clog2(DOWN_FILTER + 1);

    typedef enum logic [2:0] {
        ST_RST_GT   = 3'd0,
        ST_RST_CORE = 3'd1,
        ST_WAIT_UP  = 3'd2,
        ST_LINK_UP  = 3'd3,
        ST_RECOVER  = 3'd4,
        ST_FAILED   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [SW-1:0]    stable_q, stable_d;
    logic [LW-1:0]    low_q, low_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       drops_q, drops_d;
    logic             cu_meta_q, cu_s_q;
    logic             gt_q, gt_d, core_q, core_d, ready_q, ready_d, failed_q, failed_d;

    always_ff @(posedge init_clk or negedge RST_N) begin
        if (!RST_N) begin
            cu_meta_q <= 1'b0;
            cu_s_q    <= 1'b0;
        end else begin
            cu_meta_q <= channel_up;
            cu_s_q    <= cu_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TMR_W'(1);
        stable_d = '0;
        low_d    = '0;
        retry_d  = retry_q;
        drops_d  = drops_q;
        if (restart) begin
            state_d = ST_RST_GT;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RST_GT:   if (timer_q == TMR_W'(GT_RST_CYCLES - 1)) state_d = ST_RST_CORE;
                ST_RST_CORE: if (timer_q == TMR_W'(SYS_RST_CYCLES - 1)) state_d = ST_WAIT_UP;
                ST_WAIT_UP: begin
                    stable_d = cu_s_q ? stable_q + SW'(1) : '0;
                    if (cu_s_q && stable_q == SW'(STABLE_CYCLES - 1)) begin
                        state_d = ST_LINK_UP;
                        retry_d = '0;
                    end else if (timer_q == TMR_W'(UP_TIMEOUT - 1)) begin
                        if (retry_q == 4'(MAX_RETRIES)) begin
                            state_d = ST_FAILED;
                        end else begin
                            retry_d = retry_q + 4'd1;
                            state_d = ST_RST_GT;
                        end
                    end
                end
                ST_LINK_UP: begin
                    low_d = cu_s_q ? '0 : low_q + LW'(1);
                    if (soft_reset_req) begin
                        state_d = ST_RECOVER;
                    end else if (!cu_s_q && low_q == LW'(DOWN_FILTER - 1)) begin
                        state_d = ST_RECOVER;
                        if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
                    end
                end
                ST_RECOVER:  if (timer_q == TMR_W'(SYS_RST_CYCLES - 1)) state_d = ST_WAIT_UP;
                ST_FAILED:   state_d = ST_FAILED;
                default:     state_d = ST_RST_GT;
            endcase
        end
        // A restart inside RST_GT is not a state change but still restarts the timed sequence
        if (restart || state_d != state_q) begin
            timer_d  = '0;
            stable_d = '0;
            low_d    = '0;
        end
        gt_d     = (state_d == ST_RST_GT) || (state_d == ST_FAILED);
        core_d   = (state_d != ST_WAIT_UP) && (state_d != ST_LINK_UP);
        ready_d  = (state_d == ST_LINK_UP);
        failed_d = (state_d == ST_FAILED);
    end

    always_ff @(posedge init_clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_RST_GT;
            timer_q  <= '0;
            stable_q <= '0;
            low_q    <= '0;
            retry_q  <= '0;
            drops_q  <= '0;
            gt_q     <= 1'b1;
            core_q   <= 1'b1;
            ready_q  <= 1'b0;
            failed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            stable_q <= stable_d;
            low_q    <= low_d;
            retry_q  <= retry_d;
            drops_q  <= drops_d;
            gt_q     <= gt_d;
            core_q   <= core_d;
            ready_q  <= ready_d;
            failed_q <= failed_d;
        end
    end

    assign gt_reset     = gt_q;
    assign reset_Aurora = core_q;
    assign link_ready   = ready_q;
    assign link_failed  = failed_q;
    assign retry_cnt    = retry_q;
    assign link_drops   = drops_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// Bench for aurora_link_supervisor: directed bring-up/recovery/timeout scenarios plus random
// channel_up traffic, all checked every cycle against a phase-duration model of the supervisor.
module tb_aurora_link_supervisor;

    localparam int GT   = 62;
    localparam int SYS  = 16;
    localparam int STB  = 8;
    localparam int UPT  = 64;
    localparam int DF   = 4;
    localparam int MAXR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cu = 1'b0;
    logic       rs = 1'b0;
    logic       sr = 1'b0;
    logic       gt_reset, reset_Aurora, link_ready, link_failed;
    logic [3:0] retry_cnt;
    logic [7:0] link_drops;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    aurora_link_supervisor #(
        .GT_RST_CYCLES (GT),
        .SYS_RST_CYCLES(SYS),
        .STABLE_CYCLES (STB),
        .UP_TIMEOUT    (UPT),
        .DOWN_FILTER   (DF),
        .MAX_RETRIES   (MAXR),
        .TMR_W         (16)
    ) dut (
        .init_clk      (clk),
        .RST_N         (rst_n),
        .channel_up    (cu),
        .restart       (rs),
        .soft_reset_req(sr),
        .gt_reset      (gt_reset),
        .reset_Aurora  (reset_Aurora),
        .link_ready    (link_ready),
        .link_failed   (link_failed),
        .retry_cnt     (retry_cnt),
        .link_drops    (link_drops),
        .state_o       (state_o)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase id, cycles spent in it, current high/low runs of the synchronized input
    int m_phase = 0, m_age = 0, m_up = 0, m_dn = 0, m_retry = 0, m_drops = 0;
    bit h1 = 1'b0, h2 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_age = 0; m_up = 0; m_dn = 0; m_retry = 0; m_drops = 0;
            h1 = 1'b0; h2 = 1'b0;
        end else begin
            bit cs;
            int nxt;
            cs = h2;
            h2 = h1;
            h1 = cu;
            nxt = m_phase;
            if (rs) begin
                nxt = 0;
                m_retry = 0;
            end else begin
                case (m_phase)
                    0: if (m_age + 1 >= GT) nxt = 1;
                    1: if (m_age + 1 >= SYS) nxt = 2;
                    2: begin
                        m_up = cs ? m_up + 1 : 0;
                        if (m_up >= STB) begin
                            nxt = 3;
                            m_retry = 0;
                        end else if (m_age + 1 >= UPT) begin
                            if (m_retry == MAXR) nxt = 5;
                            else begin
                                m_retry++;
                                nxt = 0;
                            end
                        end
                    end
                    3: begin
                        m_dn = cs ? 0 : m_dn + 1;
                        if (sr) nxt = 4;
                        else if (m_dn >= DF) begin
                            nxt = 4;
                            if (m_drops < 255) m_drops++;
                        end
                    end
                    4: if (m_age + 1 >= SYS) nxt = 2;
                    default: nxt = 5;
                endcase
            end
            if (rs || nxt != m_phase) begin
                m_age = 0; m_up = 0; m_dn = 0;
            end else begin
                m_age++;
            end
            m_phase = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("state_o", 32'(state_o), m_phase);
            check("gt_reset", 32'(gt_reset), (m_phase == 0 || m_phase == 5) ? 1 : 0);
            check("reset_Aurora", 32'(reset_Aurora), (m_phase == 2 || m_phase == 3) ? 0 : 1);
            check("link_ready", 32'(link_ready), (m_phase == 3) ? 1 : 0);
            check("link_failed", 32'(link_failed), (m_phase == 5) ? 1 : 0);
            check("retry_cnt", 32'(retry_cnt), m_retry);
            check("link_drops", 32'(link_drops), m_drops);
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string nm, input int s, input int maxn, output int n);
        n = 0;
        while (32'(state_o) != s && n < maxn) begin
            edge1();
            n++;
        end
        if (32'(state_o) != s) check(nm, 32'(state_o), s);
    endtask

    initial begin
        int n, first1, first2, run;
        bit gt_seen;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_state", 32'(state_o), 0);
        check("rst_gt", 32'(gt_reset), 1);
        check("rst_core", 32'(reset_Aurora), 1);
        check("rst_ready", 32'(link_ready), 0);
        check("rst_drops", 32'(link_drops), 0);

        // Nominal bring-up
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (gt_reset === 1'b1 && n < 200) begin edge1(); n++; end
        check("gt_hold", n, 62);
        while (reset_Aurora === 1'b1 && n < 300) begin edge1(); n++; end
        check("core_hold", n, 78);
        repeat (5) edge1();
        cu = 1'b1;
        n = 0;
        while (link_ready !== 1'b1 && n < 50) begin edge1(); n++; end
        check("ready_latency", n, 10);
        check("retry_nominal", 32'(retry_cnt), 0);

        // Drop filter
        cu = 1'b0;
        repeat (3) edge1();
        cu = 1'b1;
        repeat (6) edge1();
        check("short_drop_state", 32'(state_o), 3);
        cu = 1'b0;
        wait_state("drop_wait", 4, 20, n);
        check("drop_latency", n, 6);
        check("drops_one", 32'(link_drops), 1);
        cu = 1'b1;
        n = 0;
        gt_seen = 1'b0;
        while (reset_Aurora === 1'b1 && n < 40) begin
            if (gt_reset !== 1'b0) gt_seen = 1'b1;
            edge1();
            n++;
        end
        check("recover_len", n, 16);
        check("recover_gt_low", 32'(gt_seen), 0);
        wait_state("relink_wait", 3, 40, n);
        check("relink_latency", n, 8);

        // Soft reset ignored in WAIT_UP, glitch rejection
        sr = 1'b1; edge1(); sr = 1'b0;
        check("soft_to_recover", 32'(state_o), 4);
        cu = 1'b0;
        wait_state("wait_up_wait", 2, 40, n);
        sr = 1'b1; edge1(); sr = 1'b0;
        check("soft_ignored", 32'(state_o), 2);
        cu = 1'b1; repeat (5) edge1();
        cu = 1'b0; repeat (3) edge1();
        check("glitch_no_ready", 32'(link_ready), 0);
        cu = 1'b1;
        n = 0;
        while (link_ready !== 1'b1 && n < 50) begin edge1(); n++; end
        check("glitch_latency", n, 10);

        // restart beats soft_reset_req
        rs = 1'b1; sr = 1'b1; edge1(); rs = 1'b0; sr = 1'b0;
        check("restart_state", 32'(state_o), 0);
        check("restart_gt", 32'(gt_reset), 1);
        check("restart_drops", 32'(link_drops), 1);

        // Timeouts to FAILED
        cu = 1'b0;
        n = 0; first1 = -1; first2 = -1;
        while (32'(state_o) != 5 && n < 600) begin
            edge1();
            n++;
            if (retry_cnt == 4'd1 && first1 < 0) first1 = n;
            if (retry_cnt == 4'd2 && first2 < 0) first2 = n;
        end
        check("retry1_at", first1, 142);
        check("retry2_at", first2, 284);
        check("failed_at", n, 426);
        check("failed_flag", 32'(link_failed), 1);
        check("failed_retry", 32'(retry_cnt), 2);
        repeat (20) edge1();
        check("failed_hold", 32'(state_o), 5);
        rs = 1'b1; edge1(); rs = 1'b0;
        check("unfail_state", 32'(state_o), 0);
        check("unfail_retry", 32'(retry_cnt), 0);
        check("unfail_flag", 32'(link_failed), 0);

        // Async reset mid-RECOVER
        cu = 1'b1;
        wait_state("bringup2_wait", 3, 200, n);
        check("bringup2_len", n, 86);
        sr = 1'b1; edge1(); sr = 1'b0;
        repeat (3) edge1();
        check("pre_areset_state", 32'(state_o), 4);
        #2 rst_n = 1'b0;
        #1;
        check("areset_state", 32'(state_o), 0);
        check("areset_gt", 32'(gt_reset), 1);
        check("areset_core", 32'(reset_Aurora), 1);
        check("areset_ready", 32'(link_ready), 0);
        check("areset_drops", 32'(link_drops), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        run = 0;
        for (int i = 0; i < 6000; i++) begin
            edge1();
            rst_n = (i != 3000);
            rs = ($urandom_range(0, 599) == 0);
            sr = ($urandom_range(0, 79) == 0);
            if (run == 0) begin
                int r;
                cu = ~cu;
                r = $urandom_range(0, 19);
                if (r == 0) run = $urandom_range(150, 500);
                else if (r < 6) run = $urandom_range(1, 4);
                else run = $urandom_range(5, 40);
            end else begin
                run--;
            end
        end
        edge1();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
